// File: rtl/iic_cfg_seq.sv
// -----------------------------------------------------------------------------
// iic_cfg_seq
// Power-up configuration sequencer. After an init request it waits PWR_DELAY
// cycles, then walks a register table of TABLE_DEPTH entries and hands each
// (register, data) pair to an external I2C write engine. Each write gets one
// start pulse and a handshake on the engine's busy flag, followed by
// GAP_CYCLES idle cycles before the next entry.
//
// Optional build macro:
//   IIC_CFG_TIMEOUT_EN - adds a per-write watchdog on the engine's busy
//                        handshake. If TIMEOUT_CYCLES pass in WAIT_HI/WAIT_LO,
//                        the sequence aborts to ERR and table_idx keeps the
//                        failing entry. Without it, error is tied low.
//
// Ports:
//   clk, rstn        - system clock, asynchronous active-low reset
//   init             - single-cycle request to run the table sequence
//   table_idx        - current table index (drives the external lookup)
//   table_reg        - register address at table_idx (combinational lookup)
//   table_data       - write data at table_idx (combinational lookup)
//   iic_device_addr  - 7-bit slave address (constant DEVICE_ADDR)
//   iic_reg_addr     - register address operand for the write engine
//   iic_data         - data operand for the write engine
//   iic_start        - one-cycle start pulse to the write engine
//   iic_busy         - write engine busy flag
//   active           - sequence in progress (PWR_WAIT through GAP)
//   done             - sequence completed, held until the next init
//   error            - sequence aborted by the watchdog, held until next init
// -----------------------------------------------------------------------------
module iic_cfg_seq #(
    parameter logic [6:0] DEVICE_ADDR    = 7'h3C,
    parameter int         REG_ADDR_LEN   = 8,
    parameter int         DATA_LEN       = 8,
    parameter int         TABLE_DEPTH    = 16,
    parameter int         PWR_DELAY      = 1000,
    parameter int         GAP_CYCLES     = 64,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    init,
    output logic [7:0]              table_idx,
    input  logic [REG_ADDR_LEN-1:0] table_reg,
    input  logic [DATA_LEN-1:0]     table_data,
    output logic [6:0]              iic_device_addr,
    output logic [REG_ADDR_LEN-1:0] iic_reg_addr,
    output logic [DATA_LEN-1:0]     iic_data,
    output logic                    iic_start,
    input  logic                    iic_busy,
    output logic                    active,
    output logic                    done,
    output logic                    error
);

    // One shared down-counter serves both the power-up delay and the
    // inter-write gap, so it is sized for the larger of the two.
    localparam int CNT_MAX = (PWR_DELAY > GAP_CYCLES) ? PWR_DELAY : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(PWR_DELAY - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       LAST_IDX = 8'(TABLE_DEPTH - 1);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PWR_WAIT = 4'd1,
        ST_LOAD     = 4'd2,
        ST_ISSUE    = 4'd3,
        ST_WAIT_HI  = 4'd4,
        ST_WAIT_LO  = 4'd5,
        ST_GAP      = 4'd6,
        ST_DONE     = 4'd7,
        ST_ERR      = 4'd8
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [CNT_W-1:0]        dly_cnt_r;
    logic [CNT_W-1:0]        dly_cnt_s;
    logic [7:0]              idx_r;
    logic [7:0]              idx_s;
    logic [REG_ADDR_LEN-1:0] reg_addr_r;
    logic [REG_ADDR_LEN-1:0] reg_addr_s;
    logic [DATA_LEN-1:0]     data_r;
    logic [DATA_LEN-1:0]     data_s;
    logic                    iic_start_r;
    logic                    active_r;
    logic                    done_r;
    logic                    wd_hit_s;

    // Sequence is "active" from the power-up wait through the last gap.
    function automatic logic is_active(input state_t s);
        logic r;
        case (s)
            ST_PWR_WAIT, ST_LOAD, ST_ISSUE, ST_WAIT_HI, ST_WAIT_LO, ST_GAP: r = 1'b1;
            default:                                                       r = 1'b0;
        endcase
        return r;
    endfunction

`ifdef IIC_CFG_TIMEOUT_EN
    localparam int            WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_r;
    logic            error_r;

    // Watchdog: counts cycles of the busy handshake, restarted for every write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if ((state_r == ST_WAIT_HI) || (state_r == ST_WAIT_LO)) begin
            wd_cnt_r <= wd_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
        end else begin
            wd_cnt_r <= {WD_W{1'b0}};
        end
    end

    // Limit reached on the cycle that would be the TIMEOUT_CYCLES-th wait cycle.
    always_comb begin
        wd_hit_s = 1'b0;
        if (wd_cnt_r == WD_LAST) begin
            wd_hit_s = 1'b1;
        end else begin
            wd_hit_s = 1'b0;
        end
    end

    // Error flag register, follows the next state so it is high exactly in ERR.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            error_r <= 1'b0;
        end else begin
            error_r <= (state_s == ST_ERR);
        end
    end

    assign error = error_r;
`else
    // No watchdog: the handshake waits forever and the sequence never errors.
    always_comb begin
        wd_hit_s = 1'b0;
    end

    assign error = 1'b0;
`endif

    // Next-state and datapath update logic.
    always_comb begin
        state_s    = state_r;
        dly_cnt_s  = dly_cnt_r;
        idx_s      = idx_r;
        reg_addr_s = reg_addr_r;
        data_s     = data_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (init) begin
                    state_s   = ST_PWR_WAIT;
                    dly_cnt_s = PWR_LOAD;
                    idx_s     = 8'd0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_PWR_WAIT: begin
                if (dly_cnt_r == CNT_ZERO) begin
                    state_s = ST_LOAD;
                end else begin
                    dly_cnt_s = dly_cnt_r - CNT_ONE;
                end
            end
            ST_LOAD: begin
                // Operands are captured here only and held through the handshake.
                reg_addr_s = table_reg;
                data_s     = table_data;
                state_s    = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_s = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (wd_hit_s) begin
                    state_s = ST_ERR;
                end else if (iic_busy) begin
                    state_s = ST_WAIT_LO;
                end else begin
                    state_s = ST_WAIT_HI;
                end
            end
            ST_WAIT_LO: begin
                if (wd_hit_s) begin
                    state_s = ST_ERR;
                end else if (!iic_busy) begin
                    state_s   = ST_GAP;
                    dly_cnt_s = GAP_LOAD;
                end else begin
                    state_s = ST_WAIT_LO;
                end
            end
            ST_GAP: begin
                if (dly_cnt_r != CNT_ZERO) begin
                    dly_cnt_s = dly_cnt_r - CNT_ONE;
                end else if (idx_r >= LAST_IDX) begin
                    // Last entry written; index stays saturated.
                    state_s = ST_DONE;
                end else begin
                    idx_s   = idx_r + 8'd1;
                    state_s = ST_LOAD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers: delay counter, table index and write operands.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dly_cnt_r  <= CNT_ZERO;
            idx_r      <= 8'd0;
            reg_addr_r <= {REG_ADDR_LEN{1'b0}};
            data_r     <= {DATA_LEN{1'b0}};
        end else begin
            dly_cnt_r  <= dly_cnt_s;
            idx_r      <= idx_s;
            reg_addr_r <= reg_addr_s;
            data_r     <= data_s;
        end
    end

    // Status/strobe registers decoded from the next state so they line up
    // with the state they describe without a combinational output path.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            iic_start_r <= 1'b0;
            active_r    <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            iic_start_r <= (state_s == ST_ISSUE);
            active_r    <= is_active(state_s);
            done_r      <= (state_s == ST_DONE);
        end
    end

    assign table_idx       = idx_r;
    assign iic_device_addr = DEVICE_ADDR;
    assign iic_reg_addr    = reg_addr_r;
    assign iic_data        = data_r;
    assign iic_start       = iic_start_r;
    assign active          = active_r;
    assign done            = done_r;

endmodule

// File: tb/tb_iic_cfg_seq.sv
// -----------------------------------------------------------------------------
// tb_iic_cfg_seq
// Directed bench for iic_cfg_seq with TABLE_DEPTH=3, PWR_DELAY=10,
// GAP_CYCLES=8, TIMEOUT_CYCLES=100. A small engine model raises busy one
// cycle after each start pulse and holds it for 50 cycles; it also logs the
// operands and the cycle of every start pulse.
// -----------------------------------------------------------------------------
module tb_iic_cfg_seq;

    logic       clk = 1'b0;
    logic       rstn;
    logic       init;
    logic [7:0] table_idx;
    logic [7:0] table_reg;
    logic [7:0] table_data;
    logic [6:0] iic_device_addr;
    logic [7:0] iic_reg_addr;
    logic [7:0] iic_data;
    logic       iic_start;
    logic       iic_busy;
    logic       active;
    logic       done;
    logic       error;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    // Engine model / monitor state
    int         rem       = 0;
    logic       stuck     = 1'b0;
    int         stuck_at  = -1;
    int         pulse_cnt = 0;
    int         chg_cnt   = 0;
    logic [7:0] rec_reg  [0:63];
    logic [7:0] rec_data [0:63];
    int         start_t  [0:63];

    logic [7:0] exp_reg  [0:2] = '{8'h12, 8'h34, 8'h56};
    logic [7:0] exp_data [0:2] = '{8'hA1, 8'hB2, 8'hC3};

    iic_cfg_seq #(
        .DEVICE_ADDR    (7'h3C),
        .REG_ADDR_LEN   (8),
        .DATA_LEN       (8),
        .TABLE_DEPTH    (3),
        .PWR_DELAY      (10),
        .GAP_CYCLES     (8),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .init            (init),
        .table_idx       (table_idx),
        .table_reg       (table_reg),
        .table_data      (table_data),
        .iic_device_addr (iic_device_addr),
        .iic_reg_addr    (iic_reg_addr),
        .iic_data        (iic_data),
        .iic_start       (iic_start),
        .iic_busy        (iic_busy),
        .active          (active),
        .done            (done),
        .error           (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register table lookup
    always_comb begin
        case (table_idx)
            8'd0:    begin table_reg = 8'h12; table_data = 8'hA1; end
            8'd1:    begin table_reg = 8'h34; table_data = 8'hB2; end
            8'd2:    begin table_reg = 8'h56; table_data = 8'hC3; end
            default: begin table_reg = 8'hFF; table_data = 8'hEE; end
        endcase
    end

    assign iic_busy = stuck || ((rem >= 1) && (rem <= 50));

    // Engine model: busy one cycle after start for 50 cycles; logs operands
    always @(negedge clk) begin
        if (!rstn) begin
            rem   <= 0;
            stuck <= 1'b0;
        end else begin
            if (iic_start) begin
                rem <= 51;
                if (pulse_cnt < 64) begin
                    rec_reg[pulse_cnt]  <= iic_reg_addr;
                    rec_data[pulse_cnt] <= iic_data;
                    start_t[pulse_cnt]  <= cyc;
                end
                if (pulse_cnt == stuck_at) stuck <= 1'b1;
                pulse_cnt <= pulse_cnt + 1;
            end else if (rem != 0) begin
                rem <= rem - 1;
                if (pulse_cnt > 0 && pulse_cnt <= 64) begin
                    if (iic_reg_addr !== rec_reg[pulse_cnt-1] || iic_data !== rec_data[pulse_cnt-1])
                        chg_cnt <= chg_cnt + 1;
                end
            end
        end
    end

    task automatic pulse_init(output int t0);
        @(negedge clk);
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_pulses(input int target, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (pulse_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        init = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (table_idx !== 8'd0) begin n_mis++; $display("FAIL reset_idx: got %0d want 0", table_idx); end
        n_cmp++; if (iic_start !== 1'b0) begin n_mis++; $display("FAIL reset_start: got %b want 0", iic_start); end
        n_cmp++; if (iic_reg_addr !== 8'h00) begin n_mis++; $display("FAIL reset_reg: got %h want 00", iic_reg_addr); end
        n_cmp++; if (iic_data !== 8'h00) begin n_mis++; $display("FAIL reset_data: got %h want 00", iic_data); end
        n_cmp++; if (active !== 1'b0) begin n_mis++; $display("FAIL reset_active: got %b want 0", active); end
        n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (error !== 1'b0) begin n_mis++; $display("FAIL reset_error: got %b want 0", error); end
        n_cmp++; if (iic_device_addr !== 7'h3C) begin n_mis++; $display("FAIL dev_addr: got %h want 3c", iic_device_addr); end
        n_cmp++; if (pulse_cnt !== 0) begin n_mis++; $display("FAIL reset_no_pulse: got %0d want 0", pulse_cnt); end
    endtask

    task automatic test_sequence;
        int base, t0, chg0;
        bit ok;
        base = pulse_cnt;
        chg0 = chg_cnt;
        pulse_init(t0);
        n_cmp++; if (active !== 1'b1) begin n_mis++; $display("FAIL seq_active_run: got %b want 1", active); end
        wait_done(1000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_mis++; $display("FAIL seq_done_timeout: got %b want 1", ok); end
        n_cmp++; if (pulse_cnt - base !== 3) begin n_mis++; $display("FAIL seq_pulses: got %0d want 3", pulse_cnt - base); end
        n_cmp++; if (start_t[base] - t0 !== 11) begin n_mis++; $display("FAIL seq_pwr_delay: got %0d want 11", start_t[base] - t0); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (rec_reg[base+i] !== exp_reg[i]) begin n_mis++; $display("FAIL seq_reg%0d: got %h want %h", i, rec_reg[base+i], exp_reg[i]); end
            n_cmp++; if (rec_data[base+i] !== exp_data[i]) begin n_mis++; $display("FAIL seq_data%0d: got %h want %h", i, rec_data[base+i], exp_data[i]); end
        end
        for (int i = 1; i < 3; i++) begin
            n_cmp++; if (start_t[base+i] - start_t[base+i-1] !== 61) begin n_mis++; $display("FAIL seq_spacing%0d: got %0d want 61", i, start_t[base+i] - start_t[base+i-1]); end
        end
        n_cmp++; if (chg_cnt - chg0 !== 0) begin n_mis++; $display("FAIL seq_operand_stable: got %0d changes want 0", chg_cnt - chg0); end
        n_cmp++; if (done !== 1'b1) begin n_mis++; $display("FAIL seq_done: got %b want 1", done); end
        n_cmp++; if (active !== 1'b0) begin n_mis++; $display("FAIL seq_active_end: got %b want 0", active); end
        n_cmp++; if (error !== 1'b0) begin n_mis++; $display("FAIL seq_error: got %b want 0", error); end
        n_cmp++; if (table_idx !== 8'd2) begin n_mis++; $display("FAIL seq_idx_sat: got %0d want 2", table_idx); end
        repeat (20) @(negedge clk);
        n_cmp++; if (pulse_cnt - base !== 3 || done !== 1'b1) begin n_mis++; $display("FAIL seq_idle_after: got %0d/%b want 3/1", pulse_cnt - base, done); end
    endtask

    task automatic test_rerun_from_done;
        int base, t0;
        bit ok;
        base = pulse_cnt;
        pulse_init(t0);
        n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL rerun_done_clr: got %b want 0", done); end
        n_cmp++; if (table_idx !== 8'd0) begin n_mis++; $display("FAIL rerun_idx_clr: got %0d want 0", table_idx); end
        wait_done(1000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_mis++; $display("FAIL rerun_timeout: got %b want 1", ok); end
        n_cmp++; if (pulse_cnt - base !== 3) begin n_mis++; $display("FAIL rerun_pulses: got %0d want 3", pulse_cnt - base); end
        n_cmp++; if (rec_reg[base+2] !== 8'h56) begin n_mis++; $display("FAIL rerun_reg2: got %h want 56", rec_reg[base+2]); end
    endtask

    task automatic test_init_ignored;
        int base, t0, t1;
        bit ok;
        base = pulse_cnt;
        pulse_init(t0);
        wait_pulses(base + 2, 500, ok);
        n_cmp++; if (ok !== 1'b1) begin n_mis++; $display("FAIL ign_wait: got %b want 1", ok); end
        repeat (5) @(negedge clk);
        pulse_init(t1);
        n_cmp++; if (table_idx !== 8'd1) begin n_mis++; $display("FAIL ign_idx: got %0d want 1", table_idx); end
        n_cmp++; if (active !== 1'b1) begin n_mis++; $display("FAIL ign_active: got %b want 1", active); end
        wait_done(1000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_mis++; $display("FAIL ign_done_timeout: got %b want 1", ok); end
        n_cmp++; if (pulse_cnt - base !== 3) begin n_mis++; $display("FAIL ign_pulses: got %0d want 3", pulse_cnt - base); end
        n_cmp++; if (start_t[base+2] - start_t[base+1] !== 61) begin n_mis++; $display("FAIL ign_spacing: got %0d want 61", start_t[base+2] - start_t[base+1]); end
    endtask

    task automatic test_reset_mid;
        int base, t0;
        bit ok;
        base = pulse_cnt;
        pulse_init(t0);
        wait_pulses(base + 2, 500, ok);
        n_cmp++; if (ok !== 1'b1) begin n_mis++; $display("FAIL rst_wait: got %b want 1", ok); end
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++; if (table_idx !== 8'd0 || iic_start !== 1'b0) begin n_mis++; $display("FAIL rst_idx_start: got %0d/%b want 0/0", table_idx, iic_start); end
        n_cmp++; if (iic_reg_addr !== 8'h00 || iic_data !== 8'h00) begin n_mis++; $display("FAIL rst_operands: got %h/%h want 00/00", iic_reg_addr, iic_data); end
        n_cmp++; if (active !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin n_mis++; $display("FAIL rst_status: got %b%b%b want 000", active, done, error); end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (30) @(negedge clk);
        n_cmp++; if (pulse_cnt - base !== 2 || active !== 1'b0) begin n_mis++; $display("FAIL rst_idle: got %0d/%b want 2/0", pulse_cnt - base, active); end
        base = pulse_cnt;
        pulse_init(t0);
        wait_done(1000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_mis++; $display("FAIL rst_restart_timeout: got %b want 1", ok); end
        n_cmp++; if (pulse_cnt - base !== 3) begin n_mis++; $display("FAIL rst_restart_pulses: got %0d want 3", pulse_cnt - base); end
        n_cmp++; if (rec_reg[base] !== 8'h12 || rec_data[base] !== 8'hA1) begin n_mis++; $display("FAIL rst_restart_entry0: got %h/%h want 12/a1", rec_reg[base], rec_data[base]); end
    endtask

`ifdef IIC_CFG_TIMEOUT_EN
    task automatic test_timeout;
        int base, t0, terr;
        bit ok;
        base = pulse_cnt;
        stuck_at = base + 2;
        pulse_init(t0);
        ok = 1'b0;
        terr = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (error === 1'b1) begin
                ok = 1'b1;
                terr = cyc;
                break;
            end
        end
        n_cmp++; if (ok !== 1'b1) begin n_mis++; $display("FAIL to_error: got %b want 1", ok); end
        n_cmp++; if (terr - start_t[base+2] !== 101) begin n_mis++; $display("FAIL to_latency: got %0d want 101", terr - start_t[base+2]); end
        n_cmp++; if (table_idx !== 8'd2) begin n_mis++; $display("FAIL to_idx: got %0d want 2", table_idx); end
        n_cmp++; if (active !== 1'b0 || done !== 1'b0) begin n_mis++; $display("FAIL to_status: got %b%b want 00", active, done); end
        repeat (200) @(negedge clk);
        n_cmp++; if (pulse_cnt - base !== 3 || error !== 1'b1) begin n_mis++; $display("FAIL to_no_more: got %0d/%b want 3/1", pulse_cnt - base, error); end
    endtask
`endif

    initial begin
        rstn = 1'b0;
        init = 1'b0;
        test_reset();
        test_sequence();
        test_rerun_from_done();
        test_init_ignored();
        test_reset_mid();
`ifdef IIC_CFG_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/iic_cfg_seq.md
IIC_CFG_SEQ -- requirements
Module: iic_cfg_seq

Interface
REQ-001 SHALL have parameter DEVICE_ADDR, default 7'h3C, meaning the 7-bit slave address driven on every write.
REQ-002 SHALL have parameter REG_ADDR_LEN, default 8, meaning the register address width.
REQ-003 SHALL have parameter DATA_LEN, default 8, meaning the write data width.
REQ-004 SHALL have parameter TABLE_DEPTH, default 16, meaning the number of table entries written per sequence (range 1..255).
REQ-005 SHALL have parameter PWR_DELAY, default 1000, meaning the clk cycles waited after init before the first write (range >=1).
REQ-006 SHALL have parameter GAP_CYCLES, default 64, meaning the idle clk cycles between consecutive writes (range >=1).
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the watchdog limit in clk cycles, used only under IIC_CFG_TIMEOUT_EN.
REQ-008 SHALL have clk  in  1  system clock; reset rstn, asynchronous, active-low.
REQ-009 SHALL have init  in  1  single-cycle request to run the table sequence.
REQ-010 SHALL have table_idx  out  8  current table index.
REQ-011 SHALL have table_reg  in  REG_ADDR_LEN  register address at table_idx, combinational lookup.
REQ-012 SHALL have table_data  in  DATA_LEN  data at table_idx, combinational lookup.
REQ-013 SHALL have iic_device_addr  out  7,  iic_reg_addr  out  REG_ADDR_LEN,  iic_data  out  DATA_LEN: the write engine operands.
REQ-014 SHALL have iic_start  out  1  write engine start pulse, and iic_busy  in  1  write engine busy.
REQ-015 SHALL have active  out  1,  done  out  1,  error  out  1: the sequence status.

Function
REQ-016 SHALL implement the FSM states IDLE, PWR_WAIT, LOAD, ISSUE, WAIT_HI, WAIT_LO, GAP, DONE and ERR.
REQ-017 SHALL, in IDLE, DONE or ERR, on init=1 clear table_idx, done and error, load the delay counter, and go to PWR_WAIT.
REQ-018 SHALL ignore init in all other states.
REQ-019 SHALL stay in PWR_WAIT for exactly PWR_DELAY cycles, then go to LOAD.
REQ-020 SHALL, in LOAD (one cycle), register table_reg and table_data into iic_reg_addr and iic_data, then go to ISSUE.
REQ-021 SHALL, in ISSUE, assert iic_start for exactly one cycle and go to WAIT_HI; iic_start SHALL be 0 in every other state.
REQ-022 SHALL leave WAIT_HI for WAIT_LO when iic_busy=1.
REQ-023 SHALL leave WAIT_LO for GAP when iic_busy=0.
REQ-024 SHALL hold iic_reg_addr and iic_data constant from LOAD until WAIT_LO exits.
REQ-025 SHALL stay in GAP for GAP_CYCLES cycles; at exit, if table_idx==TABLE_DEPTH-1, go to DONE, otherwise increment table_idx and go to LOAD.
REQ-026 SHALL keep table_idx saturated at TABLE_DEPTH-1, with no wrap.
REQ-027 SHALL drive active=1 in PWR_WAIT through GAP.
REQ-028 SHALL drive done=1 only in DONE and error=1 only in ERR, each held until the next init.
REQ-029 SHALL drive iic_device_addr=DEVICE_ADDR constant.
REQ-030 SHALL make the write count exactly TABLE_DEPTH iic_start pulses per sequence.

Reset
REQ-031 SHALL, on rstn=0 at any time including mid-transfer, go to IDLE and set table_idx=0, iic_start=0, iic_reg_addr=0, iic_data=0, active=0, done=0, error=0, and all counters=0.
REQ-032 SHALL require no init pulse after reset; the block idles until init.

Configuration
REQ-033 SHALL, with IIC_CFG_TIMEOUT_EN defined, count cycles spent in WAIT_HI+WAIT_LO per write and, on reaching TIMEOUT_CYCLES, go to ERR, leaving table_idx at the failing entry.
REQ-034 SHALL, without IIC_CFG_TIMEOUT_EN, omit the watchdog logic, wait in WAIT_HI and WAIT_LO indefinitely, and tie error to 0.

Verification
REQ-035 SHALL cover: TABLE_DEPTH=3, PWR_DELAY=10, engine model busy 1 cycle after start for 50 cycles, init -> exactly 3 iic_start pulses, operands match entries 0,1,2, done=1, active=0.
REQ-036 SHALL cover: operand stability -> iic_reg_addr and iic_data unchanged from LOAD through the falling edge of busy for every write, with consecutive start pulses spaced >= 50+GAP_CYCLES.
REQ-037 SHALL cover: init pulsed mid-sequence at write 1 -> ignored, with the pulse count still 3.
REQ-038 SHALL cover: rstn low during WAIT_LO of write 1 -> next cycle all outputs at reset values; a later init restarts at table_idx=0.
REQ-039 SHALL cover: IIC_CFG_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, busy stuck 1 on write 2 -> error=1 after 100 cycles, table_idx=2, no further start pulses.
REQ-040 SHALL cover: init in DONE -> done clears next cycle and the full sequence reruns.
